// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, ALU control codes, FSM encoding.
// The illegal-code check is used by alu_arbiter when ALU_ARB_CTRL_CHECK_EN is defined.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic ctrl_is_legal(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, on a tie the one
// that did not win last time is granted.
module alu_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_valid
);

    // One-hot grant selection
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign gnt_valid = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one op in flight at a time.
// Define ALU_ARB_CTRL_CHECK_EN to flag illegal ALU control codes through rsp_err.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int CW = CTRL_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*W-1:0]  req_src1,
    input  logic [2*W-1:0]  req_src2,
    input  logic [2*CW-1:0] req_ctrl,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [W-1:0]    rsp_result,
    output logic            rsp_err,
    output logic [W-1:0]    alu_src1,
    output logic [W-1:0]    alu_src2,
    output logic [CW-1:0]   alu_ctrl,
    input  logic [W-1:0]    alu_result
);

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic [W-1:0]   op_src1_q, op_src1_d;
    logic [W-1:0]   op_src2_q, op_src2_d;
    logic [CW-1:0]  op_ctrl_q, op_ctrl_d;
    logic [W-1:0]   rsp_result_q, rsp_result_d;
    logic           rsp_err_q, rsp_err_d;
    logic [1:0]     rsp_valid_q, rsp_valid_d;

    logic [1:0]     gnt_s;
    logic           gnt_valid_s;
    logic           gnt_idx_s;

    alu_arb_rr u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt_s),
        .gnt_valid  (gnt_valid_s)
    );

    assign gnt_idx_s = gnt_s[1];
    // Acceptance is only offered while idle, so a grant in IDLE is the handshake
    assign req_ready = (state_q == ST_IDLE) ? gnt_s : 2'b00;

    // Next-state and datapath register updates
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_src1_d    = op_src1_q;
        op_src2_d    = op_src2_q;
        op_ctrl_d    = op_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    op_src1_d    = gnt_idx_s ? req_src1[2*W-1:W]   : req_src1[W-1:0];
                    op_src2_d    = gnt_idx_s ? req_src2[2*W-1:W]   : req_src2[W-1:0];
                    op_ctrl_d    = gnt_idx_s ? req_ctrl[2*CW-1:CW] : req_ctrl[CW-1:0];
                    owner_d      = gnt_idx_s;
                    last_grant_d = gnt_idx_s;
                    state_d      = ST_EXEC;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_EXEC: begin
`ifdef ALU_ARB_CTRL_CHECK_EN
                if (ctrl_is_legal(op_ctrl_q)) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                end else begin
                    rsp_result_d = {W{1'b0}};
                    rsp_err_d    = 1'b1;
                end
`else
                rsp_result_d = alu_result;
                rsp_err_d    = 1'b0;
`endif
                rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (|(rsp_valid_q & rsp_ready)) begin
                    rsp_valid_d = 2'b00;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset discards any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_src1_q    <= {W{1'b0}};
            op_src2_q    <= {W{1'b0}};
            op_ctrl_q    <= {CW{1'b0}};
            rsp_result_q <= {W{1'b0}};
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_src1_q    <= op_src1_d;
            op_src2_q    <= op_src2_d;
            op_ctrl_q    <= op_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_src1   = op_src1_q;
    assign alu_src2   = op_src2_q;
    assign alu_ctrl   = op_ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus scoreboarded responses
// and directed sequences for latency, back-pressure, contention and reset.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_src1 = 32'd0;
    logic [31:0] req_src2 = 32'd0;
    logic [7:0]  req_ctrl = 8'd0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic [15:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;

`ifdef ALU_ARB_CTRL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result)
    );

    // Reference ALU: add, sub, signed set-less-than, otherwise 0
    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] c);
        case (c)
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [16:0] exp_rsp(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] c);
        if (CHK && !(c == 4'd2 || c == 4'd6 || c == 4'd7)) return {1'b1, 16'h0000};
        return {1'b0, alu_model(a, b, c)};
    endfunction

    assign alu_result = alu_model(alu_src1, alu_src2, alu_ctrl);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        owner;
        logic [16:0] rsp;
    } sb_t;

    sb_t          sb_q[$];
    int           grant_log[$];
    logic [16:0]  rsp_log[$];
    int           rsp_count = 0;
    sb_t          sb_e;

    // Scoreboard: push expected on acceptance, pop and compare on response handshake
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_owner",  {30'd0, rsp_valid}, sb_e.owner ? 32'd2 : 32'd1);
                    check("sb_result", {16'd0, rsp_result}, {16'd0, sb_e.rsp[15:0]});
                    check("sb_err",    {31'd0, rsp_err}, {31'd0, sb_e.rsp[16]});
                end
                rsp_log.push_back({rsp_err, rsp_result});
                rsp_count++;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({i[0], exp_rsp(req_src1[i*16 +: 16], req_src2[i*16 +: 16],
                                                  req_ctrl[i*4 +: 4])});
                    grant_log.push_back(i);
                end
            end
        end
    end

    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] c);
        req_src1[r*16 +: 16] = a;
        req_src2[r*16 +: 16] = b;
        req_ctrl[r*4 +: 4]   = c;
    endtask

    // Present a request and return #1 after the accepting edge
    task automatic issue(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] c);
        bit acc;
        acc = 1'b0;
        set_req(r, a, b, c);
        req_valid[r] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[r]) acc = 1'b1;
            @(posedge clk); #1;
            if (acc) break;
        end
        req_valid[r] = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp();
        int start;
        start = rsp_count;
        for (int i = 0; i < 40 && rsp_count == start; i++) begin
            @(posedge clk); #1;
        end
        if (rsp_count == start) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int          r;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  c;
        logic [15:0] er;
        logic        ee;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vecs[0] = '{0, 16'h7FFF, 16'h0001, 4'd2,  16'h8000, 1'b0};
        vecs[1] = '{1, 16'h0000, 16'h0001, 4'd6,  16'hFFFF, 1'b0};
        vecs[2] = '{0, 16'h8000, 16'h7FFF, 4'd7,  16'h0001, 1'b0};
        vecs[3] = '{1, 16'h0005, 16'h0005, 4'd7,  16'h0000, 1'b0};
        vecs[4] = '{0, 16'h0001, 16'h0001, 4'd3,  16'h0000, CHK};
        vecs[5] = '{1, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0000, CHK};
        vecs[6] = '{1, 16'hFFFF, 16'h0001, 4'd2,  16'h0000, 1'b0};

        // Reset values
        #12;
        check("rst_rsp_valid",  {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        check("rst_rsp_err",    {31'd0, rsp_err}, 32'd0);
        check("rst_req_ready",  {30'd0, req_ready}, 32'd0);
        check("rst_alu_src1",   {16'd0, alu_src1}, 32'd0);
        check("rst_alu_ctrl",   {28'd0, alu_ctrl}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b01;
        #1;
        check("post_rst_req_ready", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;

        // Single op with latency, then 5 cycles of back-pressure with req1 waiting
        rsp_ready = 2'b00;
        issue(0, 16'h7FFF, 16'h0001, 4'd2);
        check("lat_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_rsp_valid",  {30'd0, rsp_valid}, 32'd1);
        check("lat_rsp_result", {16'd0, rsp_result}, 32'h8000);
        check("lat_rsp_err",    {31'd0, rsp_err}, 32'd0);
        set_req(1, 16'h0003, 16'h0001, 4'd6);
        req_valid[1] = 1'b1;
        base = rsp_count;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid",  {30'd0, rsp_valid}, 32'd1);
            check("bp_rsp_result", {16'd0, rsp_result}, 32'h8000);
            check("bp_req_ready",  {30'd0, req_ready}, 32'd0);
        end
        req_valid[1] = 1'b0;
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        check("bp_rsp_count", rsp_count, base + 1);
        check("bp_rsp_dropped", {30'd0, rsp_valid}, 32'd0);
        check("bp_back_idle_ready", {30'd0, req_ready}, 32'd0);

        // Vector table
        rsp_ready = 2'b11;
        foreach (vecs[k]) begin
            issue(vecs[k].r, vecs[k].a, vecs[k].b, vecs[k].c);
            wait_rsp();
            if (rsp_log.size() > 0)
                check($sformatf("vec%0d_rsp", k), {15'd0, rsp_log[$]}, {15'd0, vecs[k].ee, vecs[k].er});
        end

        // Reset while the op is in EXEC: no response may ever appear
        issue(0, 16'h0001, 16'h0001, 4'd2);
        base = rsp_count;
        rst_n = 1'b0;
        #1;
        check("rstexec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rstexec_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        check("rstexec_rsp_count", rsp_count, base);
        issue(1, 16'h0009, 16'h0004, 4'd6);
        wait_rsp();
        check("rstexec_next_op", {15'd0, rsp_log[$]}, 32'h0000_0005);

        // Contention from reset: req0 first, then req1, then req0 again
        rst_n = 1'b0;
        grant_log.delete();
        rsp_log.delete();
        set_req(0, 16'h0005, 16'h0007, 4'd6);
        set_req(1, 16'hFFFF, 16'h0001, 4'd7);
        req_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("tie_first_ready", {30'd0, req_ready}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (grant_log.size() >= 1) set_req(0, 16'h0001, 16'h0002, 4'd2);
            if (grant_log.size() >= 2) req_valid[1] = 1'b0;
            if (grant_log.size() >= 3) begin
                req_valid[0] = 1'b0;
                break;
            end
        end
        check("tie_grant_count", grant_log.size(), 32'd3);
        if (grant_log.size() >= 3) begin
            check("tie_grant0", grant_log[0], 32'd0);
            check("tie_grant1", grant_log[1], 32'd1);
            check("tie_grant2", grant_log[2], 32'd0);
        end
        wait_rsp();
        check("tie_rsp_count", rsp_log.size(), 32'd3);
        if (rsp_log.size() >= 3) begin
            check("tie_rsp0", {15'd0, rsp_log[0]}, 32'h0000_FFFE);
            check("tie_rsp1", {15'd0, rsp_log[1]}, 32'h0000_0001);
            check("tie_rsp2", {15'd0, rsp_log[2]}, 32'h0000_0003);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer that shares the single combinational 16-bit ALU between two requesters, such as the execute stage and a debug/test port. It arbitrates round-robin and registers the winning operands into the ALU input ports. It then captures the ALU result and returns it through a per-requester valid/ready response channel. Only one operation is in flight at a time.

## Interface
- W, 16, data width of operands and result
- CW, 4, ALU control width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept
- req_src1  in  2×W  packed operand A, slice i for requester i
- req_src2  in  2×W  packed operand B
- req_ctrl  in  2×CW  packed ALU_CTRL code
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  W  result, shared by both requesters; qualified by rsp_valid
- rsp_err  out  1  illegal-ctrl flag, qualified by rsp_valid
- alu_src1  out  W  to ALU source1
- alu_src2  out  W  to ALU source2
- alu_ctrl  out  CW  to ALU ALU_CTRL
- alu_result  in  W  from ALU result, combinational

## Operation
- FSM states:
  - IDLE: arbitration.
  - EXEC: ALU evaluates the registered operands.
  - RESP: response held until accepted.
- Transitions:
  - IDLE→EXEC on handshake req_valid[g] & req_ready[g].
  - EXEC→RESP unconditionally.
  - RESP→IDLE on rsp_valid[g] & rsp_ready[g].
- Grant g:
  - Computed combinationally in IDLE only.
  - If one requester is valid, it wins.
  - If both are valid, the requester other than last_grant wins.
- req_ready[g] = 1 only in IDLE for the granted requester; all other req_ready bits = 0.
  - req_ready never depends on rsp_ready.
- Handshake actions:
  - Latch src1, src2 and ctrl of g into the op register.
  - Latch g into owner.
  - last_grant ← g.
- A requester may drop req_valid before acceptance; arbitration is re-evaluated every IDLE cycle.
- alu_src1/alu_src2/alu_ctrl are always driven from the op register.
  - The op register holds its value outside a handshake, so the ALU is stable in EXEC and RESP.
- EXEC:
  - rsp_result ← alu_result.
  - rsp_err ← illegal-code check (see Configuration).
- RESP:
  - rsp_valid[owner] = 1 and the other bit = 0.
  - rsp_result and rsp_err are stable until handshake.
- Arithmetic is entirely inside the ALU; this block adds no width extension or saturation.
- Legal codes: 2 add, 6 sub, 7 slt.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins first tie).
  - op register = 0.
  - rsp_result = 0, rsp_err = 0, rsp_valid = 0.
  - req_ready follows IDLE grant after reset release.
- Latency: request accepted at edge N → rsp_valid high from cycle N+2.
- Minimum issue interval: 3 cycles (rsp_ready tied high).
- Back-to-back: the RESP→IDLE handshake at edge M allows a new acceptance at edge M+1.
  - No acceptance occurs in the same cycle as a response handshake.
- Reset asserted mid-EXEC or mid-RESP:
  - The in-flight op is discarded and rsp_valid drops immediately (asynchronous).
  - No response is ever delivered for that op.
- rsp_ready asserted outside RESP is ignored.

## Configuration
- ALU_ARB_CTRL_CHECK_EN defined:
  - In EXEC, a ctrl not in {2,6,7} sets rsp_err = 1 and rsp_result = 0 regardless of alu_result.
  - Legal codes give rsp_err = 0.
- Undefined: rsp_err is tied to 0, and ctrl passes unchecked (the ALU default output of 0 is returned).

## Structure
- Shared package alu_pkg:
  - ALU_ADD = 4'd2, ALU_SUB = 4'd6, ALU_SLT = 4'd7.
  - W/CW defaults.
  - FSM state encoding (IDLE, EXEC, RESP).
- Sub-module alu_arb_rr: 2-way round-robin grant logic.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant plus a grant-valid bit.
- The top level holds the FSM, op register and response register.

## Test plan
- Reset: after rst_n low, all outputs are at reset values; first cycle after release with only req_valid = 2'b01 → req_ready = 2'b01.
- Single op: requester 0 add 0x7FFF + 0x0001 accepted at edge N → rsp_valid = 2'b01 at N+2, rsp_result = 0x8000, rsp_err = 0.
- Contention: both valid from reset, req0 sub 5 − 7, req1 slt 0xFFFF vs 0x0001, rsp_ready = 1:
  - req0 served first with result 0xFFFE.
  - req1 served next with result 0x0001.
  - A third request from req0 with both valid loses to req1 only if last_grant = 0; check that alternation holds.
- Back-pressure: rsp_ready = 0 for 5 cycles in RESP → rsp_valid/rsp_result held; req_ready = 0 throughout; handshake returns to IDLE.
- Illegal ctrl 4'd3, operands 1, 1:
  - With ALU_ARB_CTRL_CHECK_EN: rsp_err = 1, rsp_result = 0.
  - Without: rsp_err = 0, rsp_result = 0.
- Reset in EXEC: assert rst_n low one cycle after acceptance → rsp_valid never rises for that op; the next request completes normally.
